fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the single-issue RISC-V core, directly upstream of the byte-addressed, little-endian, combinational instruction memory. It owns the program counter and drives the memory address. It registers the returned 32-bit instruction with its PC into an IF/ID pipeline register, which the decoder drains over a valid/ready handshake. It accepts branch/jump redirects from execute and flushes the wrong-path instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 64, instruction memory size in bytes; power of two, at least 4.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals the PC register.
- imem_inst  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  redirect request from execute (taken branch or jump).
- redirect_pc  input  32  redirect target byte address.
- id_valid  output  1  IF/ID register holds a valid instruction.
- id_ready  input  1  decoder accepts the IF/ID contents this cycle.
- id_inst  output  32  registered instruction.
- id_pc  output  32  registered PC of id_inst.
- fetch_fault  output  1  fetch fault flag; only present in behaviour when FETCH_FAULT_EN is defined, otherwise tied to 0.

## Operation
- States:
  - BOOT: entered on reset; lasts exactly one cycle, with no fetch; transitions to RUN.
  - RUN: normal fetching.
  - FAULT: fetching stopped; only exists with FETCH_FAULT_EN.
- Advance condition in RUN: adv = !id_valid || id_ready.
- Fetch in RUN when adv and no redirect:
  - id_inst <= imem_inst
  - id_pc <= pc
  - id_valid <= 1
  - pc <= pc + 4 (32-bit, wraps 32'hFFFF_FFFC -> 0)
- Stall in RUN when !adv and no redirect: pc, id_inst, id_pc and id_valid all hold.
- Redirect has priority over fetch and stall in every state:
  - pc <= redirect_pc
  - id_valid <= 0 (flush)
  - id_inst and id_pc hold
  - from FAULT, next state is RUN
- Redirect during BOOT: pc is loaded and the state still moves to RUN.
- id_ready while id_valid=0: no effect.
- The PC is never masked to IMEM_BYTES. Address decoding and range checking belong to this block only under FETCH_FAULT_EN.

## Timing
- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC
  - id_valid = 0, id_inst = 32'h0000_0013 (nop), id_pc = RESET_PC
  - fetch_fault = 0, state = BOOT
- Latency:
  - First id_valid is asserted 2 rising edges after rst_n deasserts (BOOT, then the first fetch).
  - With id_ready held at 1, one instruction per cycle.
- Redirect penalty:
  - Redirect at edge N sets id_valid=0 after edge N.
  - The target instruction is valid after edge N+1.
- imem_inst is sampled in the same cycle imem_addr is presented; there is no extra memory latency.
- Asynchronous reset mid-operation immediately restores all reset values, including discarding a pending IF/ID instruction.

## Configuration
- FETCH_FAULT_EN defined:
  - RUN enters FAULT instead of fetching when pc[1:0] != 0 or pc >= IMEM_BYTES.
  - On that entry: fetch_fault <= 1 and id_valid <= 0 at the same edge; pc holds.
  - A redirect clears fetch_fault and returns to RUN.
  - Both fault conditions are checked again at the new pc.
- FETCH_FAULT_EN undefined:
  - No FAULT state and no range or alignment check.
  - fetch_fault is constant 0; misaligned or out-of-range PCs are fetched as-is.

## Structure
- Shared core package holds:
  - the NOP encoding 32'h0000_0013
  - the fetch state enum (BOOT, RUN, FAULT)
  - the instruction and address width constants (32)
- The IF/ID register is a natural sub-module, `ifid_reg`. It holds the valid/inst/pc capture, hold and flush logic.
- The PC, FSM and fault check stay in the top module.

## Test plan
- Reset then run with id_ready=1, memory loaded with the core's standard test program → id_pc/id_inst pairs:
  - 0x00 / 0x03C00D93
  - 0x04 / 0x0AA00E13
  - 0x08 / 0x14400E93
  - the first valid appears on the 2nd edge after reset release.
- Hold id_ready=0 for 3 cycles while id_pc=0x04 → id_pc, id_inst and imem_addr=0x08 stay constant; releasing id_ready yields 0x08 next.
- Assert redirect_valid with redirect_pc=0x14 while id_valid=1, id_ready=0 → id_valid=0 next cycle; id_pc=0x14, id_inst=0x002D8F03 the cycle after.
- Assert redirect and id_ready in the same cycle → redirect wins: flush occurs, and no PC+4 fetch is captured.
- Assert rst_n low mid-stream at pc=0x10 → pc=0x00 and id_valid=0 immediately, without waiting for a clock edge.
- With FETCH_FAULT_EN:
  - Redirect to 0x06 → fetch_fault=1, id_valid stays 0.
  - Then redirect to 0x00 → fault clears and 0x03C00D93 is fetched.
  - Run off the end past 0x3C → fault at pc=0x40.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the instruction-fetch stage: data widths,
// the NOP encoding used as the IF/ID reset filler, and the fetch FSM states.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;  // address / PC width
  localparam int unsigned ILEN = 32;  // instruction word width

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: captures a fetched instruction with its PC,
// holds it while the decoder stalls, and drops the valid bit on a flush.
// Flush wins over capture; inst/pc are left untouched by a flush.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture_i,
  input  logic            flush_i,
  input  logic [ILEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [ILEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;

  // IF/ID storage: flush clears valid only, capture loads all three, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= RESET_PC;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture_i) begin
      valid_q <= 1'b1;
      inst_q  <= inst_i;
      pc_q    <= pc_i;
    end else begin
      valid_q <= valid_q;
      inst_q  <= inst_q;
      pc_q    <= pc_q;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and feeds the IF/ID register. Redirects from execute take priority
// and flush the wrong-path instruction.
// Optional feature macro: FETCH_FAULT_EN (alignment / range fault with a
// sticky FAULT state that only a redirect leaves). Without it, fetch_fault
// is tied low and any PC is fetched as-is.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_BYTES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            fetch_fault
);

  // The memory size must be a power of two of at least one word.
  if ((IMEM_BYTES < 32'd4) || ((IMEM_BYTES & (IMEM_BYTES - 32'd1)) != 32'd0)) begin : g_bad_imem_bytes
    $error("fetch_stage: IMEM_BYTES must be a power of two >= 4");
  end

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            adv_s;
  logic            capture_s;
  logic            flush_s;

`ifdef FETCH_FAULT_EN
  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);

  logic fault_q, fault_d;
  logic fault_cond_s;

  assign fault_cond_s = (pc_q[1:0] != 2'b00) || (pc_q >= IMEM_LIMIT);
`endif

  // Decoder can take a new word when IF/ID is empty or being drained now
  assign adv_s = !id_valid || id_ready;

  // Next-state, next-PC and IF/ID control; redirect overrides everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    capture_s = 1'b0;
    flush_s   = 1'b0;
`ifdef FETCH_FAULT_EN
    fault_d   = fault_q;
`endif
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      flush_s = 1'b1;
      state_d = RUN;
`ifdef FETCH_FAULT_EN
      fault_d = 1'b0;
`endif
    end else begin
      case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN: begin
          if (adv_s) begin
`ifdef FETCH_FAULT_EN
            if (fault_cond_s) begin
              state_d = FAULT;
              fault_d = 1'b1;
              flush_s = 1'b1;
            end else begin
              capture_s = 1'b1;
              pc_d      = pc_q + 32'd4;
            end
`else
            capture_s = 1'b1;
            pc_d      = pc_q + 32'd4;
`endif
          end else begin
            pc_d = pc_q;
          end
        end
`ifdef FETCH_FAULT_EN
        FAULT: begin
          state_d = FAULT;
        end
`endif
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // PC and FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_FAULT_EN
  // Sticky fault flag, cleared only by a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_addr = pc_q;

  ifid_reg #(
    .RESET_PC (RESET_PC)
  ) u_ifid_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_i (capture_s),
    .flush_i   (flush_s),
    .inst_i    (imem_inst),
    .pc_i      (pc_q),
    .valid_o   (id_valid),
    .inst_o    (id_inst),
    .pc_o      (id_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Expected (pc, inst) pairs are queued
// as stimulus is issued; a monitor pops and compares on every decoder
// handshake. Cycle-level properties (latency, stall, flush, async reset,
// fault) are checked directly against hand-computed constants.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-byte test program memory, word-indexed by address bits [5:2]
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr[5:2])
      4'd0:    mem_word = 32'h03C0_0D93;
      4'd1:    mem_word = 32'h0AA0_0E13;
      4'd2:    mem_word = 32'h1440_0E93;
      4'd3:    mem_word = 32'h0010_0093;
      4'd4:    mem_word = 32'h0020_0113;
      4'd5:    mem_word = 32'h002D_8F03;
      4'd6:    mem_word = 32'h0030_0193;
      4'd7:    mem_word = 32'h0040_0213;
      4'd15:   mem_word = 32'h00F0_0793;
      default: mem_word = 32'h0000_0013;
    endcase
  endfunction

  assign imem_inst = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({pc, inst});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted IF/ID word must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc=%08h inst=%08h expected nothing", id_pc, id_inst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", id_pc, e.pc);
        check("sb_inst", id_inst, e.inst);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #12;
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_inst",  id_inst, 32'h0000_0013);
    check("rst_pc",    id_pc, 32'h0);
    check("rst_fault", {31'h0, fetch_fault}, 32'h0);

    // Release reset, stream with id_ready=1
    @(negedge clk);
    rst_n    = 1'b1;
    id_ready = 1'b1;
    push(32'h00, 32'h03C0_0D93);
    push(32'h04, 32'h0AA0_0E13);
    push(32'h08, 32'h1440_0E93);
    tick();  // edge 1: BOOT, no fetch
    check("boot_valid", {31'h0, id_valid}, 32'h0);
    check("boot_addr", imem_addr, 32'h0);
    tick();  // edge 2: first fetch visible
    check("first_valid", {31'h0, id_valid}, 32'h1);
    check("first_pc", id_pc, 32'h00);
    tick();  // edge 3: 0x04 in IF/ID
    check("pc04", id_pc, 32'h04);
    id_ready = 1'b0;

    // Stall three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", id_pc, 32'h04);
      check("stall_inst", id_inst, 32'h0AA0_0E13);
      check("stall_addr", imem_addr, 32'h08);
      check("stall_valid", {31'h0, id_valid}, 32'h1);
    end
    id_ready = 1'b1;
    tick();
    check("release_pc", id_pc, 32'h08);
    tick();  // 0x0C in IF/ID, will be flushed
    check("pc0c", id_pc, 32'h0C);

    // Redirect while stalled
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h14;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    check("flush_valid", {31'h0, id_valid}, 32'h0);
    check("flush_addr", imem_addr, 32'h14);
    check("flush_pc_hold", id_pc, 32'h0C);
    push(32'h14, 32'h002D_8F03);
    push(32'h18, 32'h0030_0193);
    tick();
    check("target_pc", id_pc, 32'h14);
    check("target_inst", id_inst, 32'h002D_8F03);
    tick();  // 0x18 in IF/ID

    // Redirect and id_ready together: 0x18 is drained, 0x1C is not captured
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00;
    tick();
    redirect_valid = 1'b0;
    check("rdr_rdy_valid", {31'h0, id_valid}, 32'h0);
    check("rdr_rdy_pc", id_pc, 32'h18);
    check("rdr_rdy_addr", imem_addr, 32'h00);
    push(32'h00, 32'h03C0_0D93);
    push(32'h04, 32'h0AA0_0E13);
    push(32'h08, 32'h1440_0E93);
    tick();
    tick();
    tick();
    tick();  // 0x0C in IF/ID, pc = 0x10
    check("pre_rst_addr", imem_addr, 32'h10);

    // Asynchronous reset mid-stream
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", {31'h0, id_valid}, 32'h0);
    check("arst_inst", id_inst, 32'h0000_0013);
    check("arst_pc", id_pc, 32'h0);

    // Redirect during BOOT to a misaligned address
    @(negedge clk);
    rst_n          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h06;
    tick();
    redirect_valid = 1'b0;
    check("boot_rdr_addr", imem_addr, 32'h06);
    check("boot_rdr_valid", {31'h0, id_valid}, 32'h0);
`ifdef FETCH_FAULT_EN
    tick();
    check("mis_fault", {31'h0, fetch_fault}, 32'h1);
    check("mis_valid", {31'h0, id_valid}, 32'h0);
    check("mis_addr", imem_addr, 32'h06);
    tick();
    check("mis_fault_hold", {31'h0, fetch_fault}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00;
    tick();
    redirect_valid = 1'b0;
    check("fault_clear", {31'h0, fetch_fault}, 32'h0);
    push(32'h00, 32'h03C0_0D93);
    tick();
    check("refetch_valid", {31'h0, id_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3C;
    tick();
    redirect_valid = 1'b0;
    push(32'h3C, 32'h00F0_0793);
    tick();  // 0x3C fetched, pc = 0x40
    check("last_pc", id_pc, 32'h3C);
    tick();
    check("end_fault", {31'h0, fetch_fault}, 32'h1);
    check("end_valid", {31'h0, id_valid}, 32'h0);
    check("end_addr", imem_addr, 32'h40);
`else
    push(32'h06, 32'h0AA0_0E13);
    tick();
    check("mis_fault", {31'h0, fetch_fault}, 32'h0);
    check("mis_pc", id_pc, 32'h06);
    check("mis_next", imem_addr, 32'h0A);
    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    push(32'hFFFF_FFFC, 32'h00F0_0793);
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    tick();
    id_ready = 1'b0;
    check("wrap_next_pc", id_pc, 32'h0);
`endif
    tick();
    tick();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
